// File: rtl/fsm_cpu_sender_if.sv
// Bus bundle for fsm_cpu_sender: processor valid/ready port plus the
// dado/send/ack peripheral handshake. The master modport is the sender's view.
interface fsm_cpu_sender_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] dado;
  logic [1:0]        send;
  logic [1:0]        ack;

  modport master (
    input  in_data, in_valid, ack,
    output in_ready, dado, send
  );

  modport slave (
    output in_data, in_valid, ack,
    input  in_ready, dado, send
  );
endinterface

// File: rtl/fsm_cpu_sender.sv
// fsm_cpu_sender: buffers processor words in a small FIFO and drives each one
// onto the peripheral bus with a four-phase send/ack handshake.
// Optional handshake-phase timeout is built when FSM_SENDER_TIMEOUT_EN is defined;
// otherwise the FSM waits indefinitely and err is tied low.
module fsm_cpu_sender #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  fsm_cpu_sender_if.master     bus,
  output logic                 busy,
  output logic [7:0]           sent_count,
  output logic                 err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push, pop, fifo_empty;
  logic              done, done_count;
  logic [DATA_W-1:0] dado_q;
  logic [1:0]        send_q;

  assign bus.in_ready = (count != CW'(DEPTH));
  assign fifo_empty   = (count == '0);
  assign push         = bus.in_valid && bus.in_ready;
  assign bus.dado     = dado_q;
  assign bus.send     = send_q;
  assign busy         = (state != IDLE) || !fifo_empty;

`ifdef FSM_SENDER_TIMEOUT_EN
  logic [7:0] phase_cnt;
  logic       phase_last;
  logic       tmo, tmo_drop;
  logic       dropped;
  logic       err_q;

  // Timeout fires on the edge at which the phase counter would reach TIMEOUT.
  assign phase_last = (phase_cnt == 8'(TIMEOUT - 1));
  assign err        = err_q;
  // A word abandoned in REQ must not be counted when REL later completes.
  assign done_count = done && !dropped;

  // Phase counter, sticky error and dropped-word marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt <= '0;
      err_q     <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      phase_cnt <= (state_next != state) ? '0 : phase_cnt + 8'd1;
      if (tmo)           err_q   <= 1'b1;
      if (tmo_drop)      dropped <= 1'b1;
      else if (pop)      dropped <= 1'b0;
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT;
  assign err            = 1'b0;
  assign done_count     = done;
`endif

  // FIFO storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // State register plus registered bus outputs and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      send_q     <= 2'b00;
      dado_q     <= '0;
      sent_count <= '0;
    end else begin
      state  <= state_next;
      // send is high exactly while the FSM sits in REQ
      send_q <= (state_next == REQ) ? 2'b01 : 2'b00;
      if (pop)        dado_q     <= mem[rd_ptr];
      if (done_count) sent_count <= sent_count + 8'd1;
    end
  end

  // Next-state logic, FIFO pop and handshake completion.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    done       = 1'b0;
`ifdef FSM_SENDER_TIMEOUT_EN
    tmo        = 1'b0;
    tmo_drop   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (bus.ack == 2'b01) begin
          state_next = REL;
        end
`ifdef FSM_SENDER_TIMEOUT_EN
        else if (phase_last) begin
          tmo        = 1'b1;
          tmo_drop   = 1'b1;
          state_next = REL;
        end
`endif
      end
      REL: begin
        if (bus.ack == 2'b00) begin
          done = 1'b1;
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = REQ;
          end else begin
            state_next = IDLE;
          end
        end
`ifdef FSM_SENDER_TIMEOUT_EN
        else if (phase_last) begin
          tmo        = 1'b1;
          state_next = IDLE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fsm_cpu_sender.sv
// Testbench for fsm_cpu_sender: registered-ack peripheral model with an
// override for holding ack at arbitrary values, plus a word scoreboard.
module tb_fsm_cpu_sender;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned TB_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] sent_count;
  logic       err;

  fsm_cpu_sender_if #(.DATA_W(DATA_W)) bus ();

  fsm_cpu_sender #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .sent_count(sent_count),
    .err       (err)
  );

  always #5 clk = ~clk;

  // peripheral: registered copy of send, combinational ack
  logic       p_state;
  logic       force_en  = 1'b0;
  logic [1:0] force_val = 2'b00;
  int         cyc = 0;

  always @(posedge clk) begin
    if (rst) p_state <= 1'b0;
    else     p_state <= (bus.send == 2'b01);
    cyc <= cyc + 1;
  end

  assign bus.ack = force_en ? force_val : {1'b0, p_state};

  logic [15:0] rx_q[$];
  int          rx_cyc[$];
  logic [15:0] exp_q[$];

  always @(posedge clk) begin
    if (!rst && !p_state && bus.send == 2'b01) begin
      rx_q.push_back(bus.dado);
      rx_cyc.push_back(cyc);
    end
  end

  int passed  = 0;
  int total   = 0;
  int exp_sent = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    int waited = 0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < 50) begin
      tick();
      waited++;
    end
    total++;
    if (!bus.in_ready) begin
      $display("FAIL push_accept: in_ready=%b required 1 for word %h", bus.in_ready, w);
    end else begin
      passed++;
      exp_q.push_back(w);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    logic [15:0] e, g;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    total++;
    if (busy) $display("FAIL %s_drain: busy=%b required 0 after %0d cycles", name, busy, n);
    else passed++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (rx_q.size() == 0) begin
        $display("FAIL %s_word: no word received, required %h", name, e);
      end else begin
        g = rx_q.pop_front();
        if (g !== e) $display("FAIL %s_word: got %h required %h", name, g, e);
        else passed++;
      end
    end
    if (rx_q.size() != 0) begin
      total++;
      $display("FAIL %s_extra: %0d unexpected words received", name, rx_q.size());
      rx_q.delete();
    end
    total++;
    if (sent_count !== 8'(exp_sent))
      $display("FAIL %s_count: sent_count=%0d required %0d", name, sent_count, exp_sent);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    tick();
    tick();
    total += 6;
    if (bus.send !== 2'b00) $display("FAIL reset_send: got %b required 00", bus.send); else passed++;
    if (bus.dado !== 16'h0) $display("FAIL reset_dado: got %h required 0000", bus.dado); else passed++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); else passed++;
    if (sent_count !== 8'd0) $display("FAIL reset_count: got %0d required 0", sent_count); else passed++;
    if (err !== 1'b0) $display("FAIL reset_err: got %b required 0", err); else passed++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    rx_cyc.delete();
    push_word(16'hA5C3);
    total++;
    if (bus.send !== 2'b00) $display("FAIL single_send_n: got %b required 00", bus.send); else passed++;
    tick();
    total += 2;
    if (bus.send !== 2'b01) $display("FAIL single_send_n1: got %b required 01", bus.send); else passed++;
    if (bus.dado !== 16'hA5C3) $display("FAIL single_dado: got %h required a5c3", bus.dado); else passed++;
    tick();
    tick();
    total++;
    if (bus.send !== 2'b00) $display("FAIL single_send_n3: got %b required 00", bus.send); else passed++;
    tick();
    tick();
    exp_sent++;
    total += 2;
    if (sent_count !== 8'(exp_sent)) $display("FAIL single_count_n5: got %0d required %0d", sent_count, exp_sent); else passed++;
    if (busy !== 1'b0) $display("FAIL single_busy_n5: got %b required 0", busy); else passed++;
    drain("single", 10);
  endtask

  task automatic test_back_to_back();
    rx_cyc.delete();
    for (int i = 1; i <= 4; i++) push_word(16'(i));
    exp_sent += 4;
    drain("b2b", 100);
    total++;
    if (rx_cyc.size() != 4) begin
      $display("FAIL b2b_rises: got %0d send rises required 4", rx_cyc.size());
    end else begin
      passed++;
      for (int i = 1; i < 4; i++) begin
        total++;
        if (rx_cyc[i] - rx_cyc[i-1] != 4)
          $display("FAIL b2b_spacing: got %0d cycles required 4", rx_cyc[i] - rx_cyc[i-1]);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    rx_cyc.delete();
    force_en  = 1'b1;
    force_val = 2'b00;
    for (int i = 0; i < 5; i++) push_word(16'h1000 + 16'(i));
    total += 2;
    if (bus.send !== 2'b01) $display("FAIL bp_send: got %b required 01", bus.send); else passed++;
    if (bus.dado !== 16'h1000) $display("FAIL bp_dado: got %h required 1000", bus.dado); else passed++;
    bus.in_data  = 16'hDEAD;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b required 0", bus.in_ready); else passed++;
      tick();
    end
    bus.in_valid = 1'b0;
    force_en = 1'b0;
    exp_sent += 5;
    drain("bp", 100);
  endtask

  task automatic test_ack_invalid();
    force_en  = 1'b1;
    force_val = 2'b00;
    push_word(16'h5A5A);
    tick();
    total++;
    if (bus.send !== 2'b01) $display("FAIL ackx_send_up: got %b required 01", bus.send); else passed++;
    for (int v = 2; v <= 3; v++) begin
      force_val = 2'(v);
      for (int i = 0; i < 3; i++) begin
        tick();
        total++;
        if (bus.send !== 2'b01) $display("FAIL ackx_req_hold: ack=%0d send=%b required 01", v, bus.send); else passed++;
      end
    end
    force_val = 2'b01;
    tick();
    total++;
    if (bus.send !== 2'b00) $display("FAIL ackx_send_down: got %b required 00", bus.send); else passed++;
    force_val = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    total += 2;
    if (sent_count !== 8'(exp_sent)) $display("FAIL ackx_rel_hold: sent_count=%0d required %0d", sent_count, exp_sent); else passed++;
    if (busy !== 1'b1) $display("FAIL ackx_rel_busy: got %b required 1", busy); else passed++;
    force_en = 1'b0;
    exp_sent++;
    drain("ackx", 20);
  endtask

  task automatic test_reset_mid_req();
    force_en  = 1'b1;
    force_val = 2'b00;
    for (int i = 0; i < 3; i++) push_word(16'h2000 + 16'(i));
    total++;
    if (bus.send !== 2'b01) $display("FAIL rstreq_pre_send: got %b required 01", bus.send); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total += 4;
    if (bus.send !== 2'b00) $display("FAIL rstreq_send: got %b required 00", bus.send); else passed++;
    if (bus.in_ready !== 1'b1) $display("FAIL rstreq_in_ready: got %b required 1", bus.in_ready); else passed++;
    if (busy !== 1'b0) $display("FAIL rstreq_busy: got %b required 0", busy); else passed++;
    if (sent_count !== 8'd0) $display("FAIL rstreq_count: got %0d required 0", sent_count); else passed++;
    exp_sent = 0;
    exp_q.delete();
    rx_q.delete();
    rx_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      force_val = (i % 2 == 0) ? 2'b01 : 2'b00;
      tick();
    end
    force_en = 1'b0;
    total += 3;
    if (rx_q.size() != 0) $display("FAIL rstreq_nosend: got %0d words required 0", rx_q.size()); else passed++;
    if (sent_count !== 8'd0) $display("FAIL rstreq_count_after: got %0d required 0", sent_count); else passed++;
    if (bus.send !== 2'b00) $display("FAIL rstreq_send_after: got %b required 00", bus.send); else passed++;
  endtask

`ifdef FSM_SENDER_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    force_en  = 1'b1;
    force_val = 2'b00;
    push_word(16'hBEEF);
    tick();
    while (bus.send == 2'b01 && n < 40) begin
      n++;
      tick();
    end
    total += 3;
    if (n != 8) $display("FAIL tmo_req_cycles: got %0d required 8", n); else passed++;
    if (err !== 1'b1) $display("FAIL tmo_err: got %b required 1", err); else passed++;
    if (sent_count !== 8'd0) $display("FAIL tmo_count: got %0d required 0", sent_count); else passed++;
    drain("tmo", 40);
    force_en = 1'b0;
    push_word(16'h1234);
    exp_sent++;
    drain("tmo_next", 40);
    total++;
    if (err !== 1'b1) $display("FAIL tmo_err_sticky: got %b required 1", err); else passed++;
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_ack_invalid();
    test_reset_mid_req();
`ifdef FSM_SENDER_TIMEOUT_EN
    test_timeout();
`else
    total++;
    if (err !== 1'b0) $display("FAIL err_tied: got %b required 0", err); else passed++;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
